stack_unit: RTL and testbench
=============================

// Module: stack_unit
// PURPOSE
//  Parametrised LIFO hardware stack for the CPU datapath; serves CALL/RET return
//  addresses and PUSH/POP data under control-unit push/pop strobes.
//  Generalises the fixed 16-bit stack path: configurable width and depth, a
//  selectable full-stack policy, simultaneous push+pop (replace-top), and sticky
//  overflow/underflow error flags readable by the control unit.
// PARAMETERS
//  WIDTH   16  bits per entry (matches the address/data bus width)
//  DEPTH   8   number of entries, >=2, need not be a power of two
//  WRAP    0   0 = drop pushes when full; 1 = circular, push when full overwrites oldest
// PORTS
//  clk       in   1                      system clock, all state on rising edge
//  reset     in   1                      synchronous, active-high
//  push      in   1                      write din as new top this cycle
//  pop       in   1                      remove current top this cycle
//  din       in   WIDTH                  value to push
//  clr_err   in   1                      clear sticky overflow/underflow
//  top       out  WIDTH                  current top entry (combinational from state)
//  empty     out  1                      count == 0
//  full      out  1                      count == DEPTH
//  count     out  $clog2(DEPTH+1)        number of valid entries
//  overflow  out  1                      sticky: push attempted while full
//  underflow out  1                      sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset (synchronous, priority over all inputs): count=0, stack pointer=0,
//    overflow=0, underflow=0; empty=1, full=0, top=0. Storage contents not cleared.
//  - top = newest valid entry when !empty, else 0. Reflects a push/pop on the
//    cycle after the edge that performs it (latency 1 edge, no extra stage).
//  - Storage: DEPTH x WIDTH array, circular write pointer wp modulo DEPTH;
//    top index = (wp-1) mod DEPTH; pointer arithmetic wraps DEPTH-1 -> 0 explicitly.
//  - Operation per edge (push,pop):
//    (0,0) hold.
//    (1,0) !full: mem[wp]<=din, wp++, count++.
//          full, WRAP=0: no state change except overflow<=1.
//          full, WRAP=1: mem[wp]<=din, wp++, count stays DEPTH (oldest lost), overflow<=1.
//    (0,1) !empty: wp--, count--. empty: no state change, underflow<=1.
//    (1,1) !empty: replace-top, mem[top index]<=din, wp and count unchanged,
//          no flag set (also when full).
//          empty: behaves as (1,0) push of din (count=1) and underflow<=1.
//  - Sticky flags: set as above, hold until reset or clr_err. clr_err with a new
//    error event in the same cycle: set wins (flag stays 1).
//  - Every push that fails to add depth while full also leaves top unchanged for
//    WRAP=0; for WRAP=1, top becomes din.
//  - No combinational path from push/pop/din to any output.
// TESTING  (WIDTH=16, DEPTH=4 unless stated)
//  1. Reset then push 0x1111,0x2222,0x3333 -> top=0x3333, count=3; three pops ->
//     top 0x2222,0x1111 then empty=1, top=0, underflow=0.
//  2. WRAP=0: push 0xA0..0xA3 (full=1), push 0xA4 -> count=4, top=0xA3,
//     overflow=1; clr_err -> overflow=0.
//  3. WRAP=1: push 0xB0..0xB4 -> count=4, top=0xB4, overflow=1; four pops
//     return 0xB4,0xB3,0xB2,0xB1, then empty=1.
//  4. push 0x10,0x20 then push+pop din=0x99 -> count=2, top=0x99; pop -> top=0x10.
//  5. Empty: pop -> underflow=1, count=0; push+pop din=0x55 on empty -> count=1,
//     top=0x55, underflow stays 1; clr_err and pop same cycle when empty ->
//     underflow=1.
//  6. Push 3 entries, assert reset mid-sequence together with push -> next cycle
//     count=0, empty=1, top=0, flags 0; push 0x77 -> top=0x77, count=1.

Source files
------------

// File: rtl/stack_unit.sv
// Parametrised LIFO stack with circular storage, selectable full policy, replace-top and sticky errors.
// Outputs are registered state only; push/pop/din affect outputs one edge later.
module stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int WRAP  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  input  logic                         clr_err,
  output logic [WIDTH-1:0]             top,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH-1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp, wp_n, wp_inc, wp_dec, wr_idx;
  logic [CW-1:0]    cnt, cnt_n;
  logic             we, ovf_set, unf_set;

  // Pointer wraps explicitly so DEPTH need not be a power of two.
  always_comb begin
    wp_inc = (wp == LAST) ? '0 : wp + PW'(1);
    wp_dec = (wp == '0) ? LAST : wp - PW'(1);
  end

  assign empty = (cnt == '0);
  assign full  = (cnt == FULLC);
  assign count = cnt;
  assign top   = empty ? '0 : mem[wp_dec];

  always_comb begin
    wp_n    = wp;
    cnt_n   = cnt;
    we      = 1'b0;
    wr_idx  = wp;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          we    = 1'b1;
          wp_n  = wp_inc;
          cnt_n = cnt + CW'(1);
        end else begin
          ovf_set = 1'b1;
          if (WRAP != 0) begin
            we   = 1'b1;
            wp_n = wp_inc;
          end
        end
      end
      2'b01: begin
        if (!empty) begin
          wp_n  = wp_dec;
          cnt_n = cnt - CW'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      2'b11: begin
        we = 1'b1;
        if (!empty) begin
          wr_idx = wp_dec;
        end else begin
          wp_n    = wp_inc;
          cnt_n   = CW'(1);
          unf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp        <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wp        <= wp_n;
      cnt       <= cnt_n;
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end

  // Storage is not reset; writes are simply suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (we && !reset) mem[wr_idx] <= din;
  end

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: one WRAP=0 and one WRAP=1 instance, directed vectors.
module tb_stack_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_s, push_s, pop_s, clr_s;
  logic [15:0] din_s [2];
  logic [15:0] top_o [2];
  logic [2:0]  cnt_o [2];
  logic [1:0]  emp_o, ful_o, ovf_o, unf_o;

  stack_unit #(.WIDTH(16), .DEPTH(4), .WRAP(0)) u_drop (
    .clk(clk), .reset(rst_s[0]), .push(push_s[0]), .pop(pop_s[0]), .din(din_s[0]),
    .clr_err(clr_s[0]), .top(top_o[0]), .empty(emp_o[0]), .full(ful_o[0]),
    .count(cnt_o[0]), .overflow(ovf_o[0]), .underflow(unf_o[0]));

  stack_unit #(.WIDTH(16), .DEPTH(4), .WRAP(1)) u_wrap (
    .clk(clk), .reset(rst_s[1]), .push(push_s[1]), .pop(pop_s[1]), .din(din_s[1]),
    .clr_err(clr_s[1]), .top(top_o[1]), .empty(emp_o[1]), .full(ful_o[1]),
    .count(cnt_o[1]), .overflow(ovf_o[1]), .underflow(unf_o[1]));

  typedef struct {
    int          sel;
    int          id;
    logic [15:0] top;
    logic [2:0]  cnt;
    logic        emp, ful, ovf, unf;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int step  = 0;

  task automatic chk(input string name, input int id, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step=%0d got=0x%0h want=0x%0h", name, id, act, req);
    end
  endtask

  // Monitor: DUT outputs are settled at the falling edge after the operating edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("top",       e.id, int'(top_o[e.sel]), int'(e.top));
      chk("count",     e.id, int'(cnt_o[e.sel]), int'(e.cnt));
      chk("empty",     e.id, int'(emp_o[e.sel]), int'(e.emp));
      chk("full",      e.id, int'(ful_o[e.sel]), int'(e.ful));
      chk("overflow",  e.id, int'(ovf_o[e.sel]), int'(e.ovf));
      chk("underflow", e.id, int'(unf_o[e.sel]), int'(e.unf));
    end
  end

  task automatic op(input int s, input logic p, input logic o, input logic [15:0] d,
                    input logic c, input logic r);
    @(negedge clk);
    push_s[s] = p; pop_s[s] = o; din_s[s] = d; clr_s[s] = c; rst_s[s] = r;
    @(posedge clk);
    #1;
    push_s[s] = 1'b0; pop_s[s] = 1'b0; clr_s[s] = 1'b0; rst_s[s] = 1'b0;
  endtask

  task automatic expect_st(input int s, input logic [15:0] t, input logic [2:0] c,
                           input logic e, input logic f, input logic ov, input logic un);
    exp_t x;
    x.sel = s; x.id = step; x.top = t; x.cnt = c;
    x.emp = e; x.ful = f; x.ovf = ov; x.unf = un;
    q.push_back(x);
    step++;
  endtask

  // Each row: op then the state expected right after that edge.
  task automatic run(input int s, input logic p, input logic o, input logic [15:0] d,
                     input logic c, input logic r, input logic [15:0] t, input logic [2:0] n,
                     input logic e, input logic f, input logic ov, input logic un);
    op(s, p, o, d, c, r);
    expect_st(s, t, n, e, f, ov, un);
  endtask

  initial begin
    rst_s = '0; push_s = '0; pop_s = '0; clr_s = '0;
    din_s[0] = '0; din_s[1] = '0;

    // s  psh pop din     clr rst  top     cnt emp ful ov un
    run(0, 0, 0, 16'h0,    0, 1,  16'h0,    0, 1, 0, 0, 0);
    run(1, 0, 0, 16'h0,    0, 1,  16'h0,    0, 1, 0, 0, 0);
    // basic push/pop
    run(0, 1, 0, 16'h1111, 0, 0,  16'h1111, 1, 0, 0, 0, 0);
    run(0, 1, 0, 16'h2222, 0, 0,  16'h2222, 2, 0, 0, 0, 0);
    run(0, 1, 0, 16'h3333, 0, 0,  16'h3333, 3, 0, 0, 0, 0);
    run(0, 0, 1, 16'h0,    0, 0,  16'h2222, 2, 0, 0, 0, 0);
    run(0, 0, 1, 16'h0,    0, 0,  16'h1111, 1, 0, 0, 0, 0);
    run(0, 0, 1, 16'h0,    0, 0,  16'h0,    0, 1, 0, 0, 0);
    // drop-when-full
    run(0, 1, 0, 16'hA0,   0, 0,  16'hA0,   1, 0, 0, 0, 0);
    run(0, 1, 0, 16'hA1,   0, 0,  16'hA1,   2, 0, 0, 0, 0);
    run(0, 1, 0, 16'hA2,   0, 0,  16'hA2,   3, 0, 0, 0, 0);
    run(0, 1, 0, 16'hA3,   0, 0,  16'hA3,   4, 0, 1, 0, 0);
    run(0, 1, 0, 16'hA4,   0, 0,  16'hA3,   4, 0, 1, 1, 0);
    run(0, 0, 0, 16'h0,    1, 0,  16'hA3,   4, 0, 1, 0, 0);
    run(0, 0, 1, 16'h0,    0, 0,  16'hA2,   3, 0, 0, 0, 0);
    run(0, 0, 0, 16'h0,    0, 1,  16'h0,    0, 1, 0, 0, 0);
    // replace-top
    run(0, 1, 0, 16'h10,   0, 0,  16'h10,   1, 0, 0, 0, 0);
    run(0, 1, 0, 16'h20,   0, 0,  16'h20,   2, 0, 0, 0, 0);
    run(0, 1, 1, 16'h99,   0, 0,  16'h99,   2, 0, 0, 0, 0);
    run(0, 0, 1, 16'h0,    0, 0,  16'h10,   1, 0, 0, 0, 0);
    run(0, 0, 1, 16'h0,    0, 0,  16'h0,    0, 1, 0, 0, 0);
    // underflow handling
    run(0, 0, 1, 16'h0,    0, 0,  16'h0,    0, 1, 0, 0, 1);
    run(0, 1, 1, 16'h55,   0, 0,  16'h55,   1, 0, 0, 0, 1);
    run(0, 0, 1, 16'h0,    0, 0,  16'h0,    0, 1, 0, 0, 1);
    run(0, 0, 1, 16'h0,    1, 0,  16'h0,    0, 1, 0, 0, 1);
    run(0, 0, 0, 16'h0,    1, 0,  16'h0,    0, 1, 0, 0, 0);
    // reset mid-sequence with a push
    run(0, 0, 1, 16'h0,    0, 0,  16'h0,    0, 1, 0, 0, 1);
    run(0, 1, 0, 16'h1,    0, 0,  16'h1,    1, 0, 0, 0, 1);
    run(0, 1, 0, 16'h2,    0, 0,  16'h2,    2, 0, 0, 0, 1);
    run(0, 1, 0, 16'h3,    0, 0,  16'h3,    3, 0, 0, 0, 1);
    run(0, 1, 0, 16'h44,   0, 1,  16'h0,    0, 1, 0, 0, 0);
    run(0, 1, 0, 16'h77,   0, 0,  16'h77,   1, 0, 0, 0, 0);
    // circular overwrite
    run(1, 1, 0, 16'hB0,   0, 0,  16'hB0,   1, 0, 0, 0, 0);
    run(1, 1, 0, 16'hB1,   0, 0,  16'hB1,   2, 0, 0, 0, 0);
    run(1, 1, 0, 16'hB2,   0, 0,  16'hB2,   3, 0, 0, 0, 0);
    run(1, 1, 0, 16'hB3,   0, 0,  16'hB3,   4, 0, 1, 0, 0);
    run(1, 1, 0, 16'hB4,   0, 0,  16'hB4,   4, 0, 1, 1, 0);
    run(1, 0, 1, 16'h0,    0, 0,  16'hB3,   3, 0, 0, 1, 0);
    run(1, 0, 1, 16'h0,    0, 0,  16'hB2,   2, 0, 0, 1, 0);
    run(1, 0, 1, 16'h0,    0, 0,  16'hB1,   1, 0, 0, 1, 0);
    run(1, 0, 1, 16'h0,    0, 0,  16'h0,    0, 1, 0, 1, 0);
    // replace-top while full sets no flag
    run(1, 0, 0, 16'h0,    1, 0,  16'h0,    0, 1, 0, 0, 0);
    run(1, 1, 0, 16'hC0,   0, 0,  16'hC0,   1, 0, 0, 0, 0);
    run(1, 1, 0, 16'hC1,   0, 0,  16'hC1,   2, 0, 0, 0, 0);
    run(1, 1, 0, 16'hC2,   0, 0,  16'hC2,   3, 0, 0, 0, 0);
    run(1, 1, 0, 16'hC3,   0, 0,  16'hC3,   4, 0, 1, 0, 0);
    run(1, 1, 1, 16'hD0,   0, 0,  16'hD0,   4, 0, 1, 0, 0);
    run(1, 0, 1, 16'h0,    0, 0,  16'hC2,   3, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
